// File: rtl/luma_gain_clip_pipe_if.sv
// Stream bundle for luma_gain_clip_pipe: input beat, output beat and clip counter.
// The pipeline is the slave; the sample source / formatter side is the master.
interface luma_gain_clip_pipe_if #(
  parameter int LUMA_W = 8,
  parameter int GAIN_W = 4,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16
);
  // Valid/ready: a beat moves on a rising CLK edge where valid && ready are both high.
  // A producer holding valid keeps its payload stable until that edge; ready may
  // change freely and never depends combinationally on the same side's valid.
  logic              IN_VALID;
  logic              IN_READY;
  logic [LUMA_W-1:0] LUMA;
  logic [GAIN_W-1:0] GAIN;
  logic [OUT_W-1:0]  CLIP_MAX;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [OUT_W-1:0]  PRODUCT;
  logic              CLIPPED;
  logic              CNT_CLR;
  logic [CNT_W-1:0]  CLIP_CNT;

  modport slave (
    input  IN_VALID, LUMA, GAIN, CLIP_MAX, OUT_READY, CNT_CLR,
    output IN_READY, OUT_VALID, PRODUCT, CLIPPED, CLIP_CNT
  );

  modport master (
    output IN_VALID, LUMA, GAIN, CLIP_MAX, OUT_READY, CNT_CLR,
    input  IN_READY, OUT_VALID, PRODUCT, CLIPPED, CLIP_CNT
  );
endinterface

// File: rtl/luma_gain_clip_pipe.sv
// Two-stage luma*gain scaler with runtime saturation ceiling and clip-event counter.
// Optional macro LGC_ROUND_EN selects round-half-up instead of truncation on the shift.
module luma_gain_clip_pipe #(
  parameter int LUMA_W = 8,
  parameter int GAIN_W = 4,
  parameter int FRAC_W = 2,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16
) (
  input logic                   CLK,
  input logic                   RST_N,
  luma_gain_clip_pipe_if.slave  bus
);

  localparam int RAW_W = LUMA_W + GAIN_W;
  localparam int SUM_W = RAW_W + 1;
  localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;

  // Stage 1: raw product and the ceiling captured with the beat
  logic              s1_valid;
  logic [RAW_W-1:0]  s1_raw;
  logic [OUT_W-1:0]  s1_clip_max;

  // Stage 2: output register
  logic              s2_valid;
  logic [OUT_W-1:0]  s2_product;
  logic              s2_clipped;
  logic [CNT_W-1:0]  clip_cnt_q;

  logic              s1_ready;
  logic              s2_ready;
  logic              out_fire;
  logic [SUM_W-1:0]  shifted;
  logic [CMP_W-1:0]  shifted_cmp;
  logic [CMP_W-1:0]  clip_cmp;
  logic              sat;
  logic [OUT_W-1:0]  next_product;

  assign s2_ready = !s2_valid || bus.OUT_READY;
  assign s1_ready = !s1_valid || s2_ready;
  assign out_fire = s2_valid && bus.OUT_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid    <= 1'b0;
      s1_raw      <= '0;
      s1_clip_max <= '0;
    end else if (s1_ready) begin
      s1_valid <= bus.IN_VALID;
      if (bus.IN_VALID) begin
        s1_raw      <= RAW_W'(bus.LUMA) * RAW_W'(bus.GAIN);
        s1_clip_max <= bus.CLIP_MAX;
      end
    end
  end

`ifdef LGC_ROUND_EN
  // (2**FRAC_W)/2 collapses to zero when there are no fractional bits
  localparam logic [SUM_W-1:0] RND_TERM = SUM_W'((2 ** FRAC_W) / 2);
`endif

  always_comb begin
`ifdef LGC_ROUND_EN
    shifted = (SUM_W'(s1_raw) + RND_TERM) >> FRAC_W;
`else
    shifted = SUM_W'(s1_raw) >> FRAC_W;
`endif
    shifted_cmp  = CMP_W'(shifted);
    clip_cmp     = CMP_W'(s1_clip_max);
    sat          = shifted_cmp > clip_cmp;
    next_product = sat ? s1_clip_max : shifted_cmp[OUT_W-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_valid   <= 1'b0;
      s2_product <= '0;
      s2_clipped <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_product <= next_product;
        s2_clipped <= sat;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clip_cnt_q <= '0;
    end else if (bus.CNT_CLR) begin
      clip_cnt_q <= '0;
    end else if (out_fire && s2_clipped && !(&clip_cnt_q)) begin
      clip_cnt_q <= clip_cnt_q + 1'b1;
    end
  end

  assign bus.IN_READY  = s1_ready;
  assign bus.OUT_VALID = s2_valid;
  assign bus.PRODUCT   = s2_product;
  assign bus.CLIPPED   = s2_clipped;
  assign bus.CLIP_CNT  = clip_cnt_q;

endmodule

// File: tb/tb_luma_gain_clip_pipe.sv
// Directed bench for luma_gain_clip_pipe: default-parameter instance plus a CNT_W=2
// instance for counter saturation.
module tb_luma_gain_clip_pipe;

  logic CLK;
  logic RST_N;
  int   checks = 0;
  int   errors = 0;

`ifdef LGC_ROUND_EN
  localparam int EXP_T1 = 113;
`else
  localparam int EXP_T1 = 112;
`endif

  luma_gain_clip_pipe_if #(.LUMA_W(8), .GAIN_W(4), .OUT_W(8), .CNT_W(16)) if_a ();
  luma_gain_clip_pipe_if #(.LUMA_W(8), .GAIN_W(4), .OUT_W(8), .CNT_W(2))  if_b ();

  luma_gain_clip_pipe #(.LUMA_W(8), .GAIN_W(4), .FRAC_W(2), .OUT_W(8), .CNT_W(16)) dut_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (if_a.slave)
  );

  luma_gain_clip_pipe #(.LUMA_W(8), .GAIN_W(4), .FRAC_W(2), .OUT_W(8), .CNT_W(2)) dut_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (if_b.slave)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] l, input logic [3:0] g, input logic [7:0] c);
    if_a.IN_VALID = 1'b1;
    if_a.LUMA     = l;
    if_a.GAIN     = g;
    if_a.CLIP_MAX = c;
    step();
    if_a.IN_VALID = 1'b0;
  endtask

  task automatic wait_a(input string tag);
    int n = 0;
    while (if_a.OUT_VALID !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, 32'(if_a.OUT_VALID), 1);
  endtask

  task automatic wait_b(input string tag);
    int n = 0;
    while (if_b.OUT_VALID !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, 32'(if_b.OUT_VALID), 1);
  endtask

  initial begin
    RST_N         = 1'b0;
    if_a.IN_VALID = 1'b0; if_a.LUMA = '0; if_a.GAIN = '0; if_a.CLIP_MAX = '0;
    if_a.OUT_READY = 1'b1; if_a.CNT_CLR = 1'b0;
    if_b.IN_VALID = 1'b0; if_b.LUMA = '0; if_b.GAIN = '0; if_b.CLIP_MAX = '0;
    if_b.OUT_READY = 1'b1; if_b.CNT_CLR = 1'b0;

    // reset state
    #2;
    chk("rst_out_valid", 32'(if_a.OUT_VALID), 0);
    chk("rst_product",   32'(if_a.PRODUCT),   0);
    chk("rst_clipped",   32'(if_a.CLIPPED),   0);
    chk("rst_clip_cnt",  32'(if_a.CLIP_CNT),  0);
    chk("rst_b_out_valid", 32'(if_b.OUT_VALID), 0);
    #20 RST_N = 1'b1;
    step();
    chk("in_ready_after_rst", 32'(if_a.IN_READY), 1);

    // 1: 30*15=450 >> 2, two-cycle latency
    if_a.IN_VALID = 1'b1; if_a.LUMA = 8'd30; if_a.GAIN = 4'd15; if_a.CLIP_MAX = 8'd255;
    step();
    if_a.IN_VALID = 1'b0;
    chk("t1_lat1_out_valid", 32'(if_a.OUT_VALID), 0);
    step();
    chk("t1_out_valid", 32'(if_a.OUT_VALID), 1);
    chk("t1_product",   32'(if_a.PRODUCT),   EXP_T1);
    chk("t1_clipped",   32'(if_a.CLIPPED),   0);
    step();
    chk("t1_drained",   32'(if_a.OUT_VALID), 0);

    // 2: saturation against 255 and against a lower ceiling
    send_a(8'd255, 4'd15, 8'd255);
    wait_a("t2a");
    chk("t2a_product", 32'(if_a.PRODUCT), 255);
    chk("t2a_clipped", 32'(if_a.CLIPPED), 1);
    chk("t2a_cnt_before", 32'(if_a.CLIP_CNT), 0);
    step();
    chk("t2a_cnt", 32'(if_a.CLIP_CNT), 1);
    send_a(8'd30, 4'd15, 8'd100);
    wait_a("t2b");
    chk("t2b_product", 32'(if_a.PRODUCT), 100);
    chk("t2b_clipped", 32'(if_a.CLIPPED), 1);
    step();
    chk("t2b_cnt", 32'(if_a.CLIP_CNT), 2);

    // 3: backpressure, 4 beats: 10*4->10, 20*5->25, 40*6->60, 100*7->175
    if_a.OUT_READY = 1'b0;
    if_a.IN_VALID = 1'b1; if_a.LUMA = 8'd10; if_a.GAIN = 4'd4; if_a.CLIP_MAX = 8'd255;
    chk("bp_in_ready_b0", 32'(if_a.IN_READY), 1);
    step();
    if_a.LUMA = 8'd20; if_a.GAIN = 4'd5;
    chk("bp_in_ready_b1", 32'(if_a.IN_READY), 1);
    step();
    if_a.LUMA = 8'd40; if_a.GAIN = 4'd6;
    chk("bp_in_ready_full", 32'(if_a.IN_READY), 0);
    chk("bp_out_valid",     32'(if_a.OUT_VALID), 1);
    chk("bp_product_b0",    32'(if_a.PRODUCT), 10);
    step();
    step();
    chk("bp_in_ready_hold",  32'(if_a.IN_READY), 0);
    chk("bp_out_valid_hold", 32'(if_a.OUT_VALID), 1);
    chk("bp_product_hold",   32'(if_a.PRODUCT), 10);
    chk("bp_clipped_hold",   32'(if_a.CLIPPED), 0);
    if_a.OUT_READY = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(if_a.IN_READY), 1);
    step();
    if_a.LUMA = 8'd100; if_a.GAIN = 4'd7;
    chk("bp_product_b1", 32'(if_a.PRODUCT), 25);
    step();
    if_a.IN_VALID = 1'b0;
    chk("bp_product_b2", 32'(if_a.PRODUCT), 60);
    step();
    chk("bp_product_b3", 32'(if_a.PRODUCT), 175);
    chk("bp_valid_b3",   32'(if_a.OUT_VALID), 1);
    step();
    chk("bp_no_dup",     32'(if_a.OUT_VALID), 0);
    chk("bp_cnt",        32'(if_a.CLIP_CNT), 2);

    // 4: zero ceiling
    send_a(8'd0, 4'd15, 8'd0);
    wait_a("t4a");
    chk("t4a_product", 32'(if_a.PRODUCT), 0);
    chk("t4a_clipped", 32'(if_a.CLIPPED), 0);
    step();
    send_a(8'd1, 4'd4, 8'd0);
    wait_a("t4b");
    chk("t4b_product", 32'(if_a.PRODUCT), 0);
    chk("t4b_clipped", 32'(if_a.CLIPPED), 1);
    step();
    chk("t4b_cnt", 32'(if_a.CLIP_CNT), 3);

    // 5: CNT_W=2 saturation, then clear racing a clipped transfer
    if_b.IN_VALID = 1'b1; if_b.LUMA = 8'd255; if_b.GAIN = 4'd15; if_b.CLIP_MAX = 8'd255;
    repeat (5) step();
    if_b.IN_VALID = 1'b0;
    chk("b_cnt_three", 32'(if_b.CLIP_CNT), 3);
    repeat (3) step();
    chk("b_cnt_sat",   32'(if_b.CLIP_CNT), 3);
    chk("b_drained",   32'(if_b.OUT_VALID), 0);
    if_b.IN_VALID = 1'b1;
    step();
    if_b.IN_VALID = 1'b0;
    wait_b("b_clr");
    chk("b_clr_clipped", 32'(if_b.CLIPPED), 1);
    if_b.CNT_CLR = 1'b1;
    step();
    if_b.CNT_CLR = 1'b0;
    chk("b_cnt_clr", 32'(if_b.CLIP_CNT), 0);
    chk("b_clr_out_valid", 32'(if_b.OUT_VALID), 0);

    // 6: async reset with two beats in flight
    send_a(8'd50, 4'd8, 8'd255);
    if_a.IN_VALID = 1'b1; if_a.LUMA = 8'd60;
    step();
    if_a.IN_VALID = 1'b0;
    chk("pre_rst_out_valid", 32'(if_a.OUT_VALID), 1);
    chk("pre_rst_product",   32'(if_a.PRODUCT), 100);
    #3 RST_N = 1'b0;
    #1;
    chk("arst_out_valid", 32'(if_a.OUT_VALID), 0);
    chk("arst_product",   32'(if_a.PRODUCT), 0);
    chk("arst_clipped",   32'(if_a.CLIPPED), 0);
    chk("arst_clip_cnt",  32'(if_a.CLIP_CNT), 0);
    #10 RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_in_ready",  32'(if_a.IN_READY), 1);
      chk("post_rst_no_stale",  32'(if_a.OUT_VALID), 0);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
